// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants for the 4:1 mux scan sequencer.
package mux_scan_ctrl_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_ctrl_next_ch.sv
// Priority picker: lowest enabled channel overall, or lowest enabled above cur_i.
module mux_next_ch
    import mux_scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0]   m_i,
    input  logic [SEL_W-1:0] cur_i,
    input  logic             first_i,
    output logic [SEL_W-1:0] next_o,
    output logic             last_o
);

    // Descending walk so the lowest qualifying channel is the one that sticks.
    always_comb begin
        next_o = '0;
        last_o = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m_i[i] && (first_i || (SEL_W'(i) > cur_i))) begin
                next_o = SEL_W'(i);
                last_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the mux select, dwells per enabled channel, samples Y and assembles a frame.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [NCH-1:0]   mask_i,
    input  logic             y_i,
    output logic [SEL_W-1:0] s_o,
    output logic             busy_o,
    output logic             sample_valid_o,
    output logic [SEL_W-1:0] sample_ch_o,
    output logic             sample_bit_o,
    output logic [NCH-1:0]   frame_o,
    output logic             frame_valid_o
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DWELL - 1);

    logic [0:0]       state_q, state_d;
    logic [NCH-1:0]   m_q, m_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   acc_q, acc_d;
    logic [NCH-1:0]   frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sample_valid_q, sample_valid_d;
    logic [SEL_W-1:0] sample_ch_q, sample_ch_d;
    logic             sample_bit_q, sample_bit_d;

    logic [SEL_W-1:0] first_ch, nxt_ch;
    logic             mask_empty, nxt_last;
    logic [NCH-1:0]   acc_smp;

    // Picks the first channel of a freshly latched mask; last_o doubles as mask==0.
    mux_next_ch u_first (
        .m_i     (mask_i),
        .cur_i   (s_q),
        .first_i (1'b1),
        .next_o  (first_ch),
        .last_o  (mask_empty)
    );

    mux_next_ch u_next (
        .m_i     (m_q),
        .cur_i   (s_q),
        .first_i (1'b0),
        .next_o  (nxt_ch),
        .last_o  (nxt_last)
    );

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        s_d            = s_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        frame_d        = frame_q;
        frame_valid_d  = 1'b0;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_bit_d   = sample_bit_q;
        acc_smp        = acc_q;
        acc_smp[s_q]   = y_i;

        case (state_q)
            IDLE: begin
                if (start_i && !mask_empty) begin
                    state_d = SCAN;
                    m_d     = mask_i;
                    s_d     = first_ch;
                    cnt_d   = CntLoad;
                    acc_d   = '0;
                end
            end
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sample_valid_d = 1'b1;
                    sample_ch_d    = s_q;
                    sample_bit_d   = y_i;
                    acc_d          = acc_smp;
                    if (!nxt_last) begin
                        s_d   = nxt_ch;
                        cnt_d = CntLoad;
                    end else begin
                        frame_d       = acc_smp;
                        frame_valid_d = 1'b1;
                        // Continuous restart begins the next frame with no gap cycle.
                        if (cont_i && !mask_empty) begin
                            m_d   = mask_i;
                            s_d   = first_ch;
                            cnt_d = CntLoad;
                            acc_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            m_q            <= '0;
            s_q            <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            frame_q        <= '0;
            frame_valid_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            sample_bit_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            s_q            <= s_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            frame_q        <= frame_d;
            frame_valid_q  <= frame_valid_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_bit_q   <= sample_bit_d;
        end
    end

    assign s_o            = s_q;
    assign busy_o         = (state_q == SCAN);
    assign sample_valid_o = sample_valid_q;
    assign sample_ch_o    = sample_ch_q;
    assign sample_bit_o   = sample_bit_q;
    assign frame_o        = frame_q;
    assign frame_valid_o  = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (dwell 4, 2, 1) each fed by a modelled 4:1 mux.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst   [3];
    logic       start [3];
    logic       cont  [3];
    logic [3:0] mask  [3];
    logic [3:0] yv    [3];
    logic       y     [3];
    logic [1:0] s     [3];
    logic       busy  [3];
    logic       sv    [3];
    logic [1:0] sch   [3];
    logic       sbit  [3];
    logic [3:0] frame [3];
    logic       fv    [3];

    logic [3:0] frame_m [3];
    logic [1:0] s_m     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DW = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        mux_scan_ctrl #(
            .DWELL (DW),
            .CNT_W (8)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst[g]),
            .start_i        (start[g]),
            .cont_i         (cont[g]),
            .mask_i         (mask[g]),
            .y_i            (y[g]),
            .s_o            (s[g]),
            .busy_o         (busy[g]),
            .sample_valid_o (sv[g]),
            .sample_ch_o    (sch[g]),
            .sample_bit_o   (sbit[g]),
            .frame_o        (frame[g]),
            .frame_valid_o  (fv[g])
        );
        assign y[g] = yv[g][s[g]];
    end

    function automatic int dw(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int d, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic idle_check(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_busy", d, 4'(busy[d]), 4'd0);
            chk("idle_sv", d, 4'(sv[d]), 4'd0);
            chk("idle_fv", d, 4'(fv[d]), 4'd0);
            chk("idle_frame", d, frame[d], frame_m[d]);
            chk("idle_s", d, 4'(s[d]), 4'(s_m[d]));
        end
    endtask

    // One frame scanned from the enabled-channel list; expectations derive from edge counts.
    task automatic do_scan(input int d, input logic [3:0] msk, input logic cont_v,
                           input logic [3:0] mask_after, input bit need_start, input bit poke);
        int q[$];
        int k, dd, pos;
        logic [3:0] expf;
        logic end_busy;
        logic [1:0] end_s;
        for (int i = 0; i < 4; i++) if (msk[i]) q.push_back(i);
        k        = q.size();
        dd       = dw(d);
        expf     = msk & yv[d];
        end_busy = cont_v && (mask_after != 4'd0);
        end_s    = end_busy ? lowest(mask_after) : 2'(q[k-1]);
        if (need_start) begin
            start[d] = 1'b1;
            mask[d]  = msk;
            step();
            start[d] = 1'b0;
            chk("c0_s", d, 4'(s[d]), 4'(q[0]));
            chk("c0_busy", d, 4'(busy[d]), 4'd1);
            chk("c0_sv", d, 4'(sv[d]), 4'd0);
            chk("c0_fv", d, 4'(fv[d]), 4'd0);
        end
        mask[d] = mask_after;
        cont[d] = cont_v;
        for (int e = 1; e <= k * dd; e++) begin
            if (poke && e == 1) start[d] = 1'b1;
            step();
            start[d] = 1'b0;
            pos = e / dd;
            if (e == k * dd) begin
                chk("end_s", d, 4'(s[d]), 4'(end_s));
                chk("end_busy", d, 4'(busy[d]), 4'(end_busy));
                chk("end_sv", d, 4'(sv[d]), 4'd1);
                chk("end_sch", d, 4'(sch[d]), 4'(q[k-1]));
                chk("end_sbit", d, 4'(sbit[d]), 4'(yv[d][q[k-1]]));
                chk("end_fv", d, 4'(fv[d]), 4'd1);
                chk("end_frame", d, frame[d], expf);
                frame_m[d] = expf;
                s_m[d]     = end_s;
            end else begin
                chk("run_s", d, 4'(s[d]), 4'(q[pos]));
                chk("run_busy", d, 4'(busy[d]), 4'd1);
                chk("run_fv", d, 4'(fv[d]), 4'd0);
                chk("run_frame", d, frame[d], frame_m[d]);
                chk("run_sv", d, 4'(sv[d]), 4'((e % dd) == 0));
                if ((e % dd) == 0) begin
                    chk("run_sch", d, 4'(sch[d]), 4'(q[pos-1]));
                    chk("run_sbit", d, 4'(sbit[d]), 4'(yv[d][q[pos-1]]));
                end
            end
        end
    endtask

    initial begin
        logic [3:0] cur, nm;
        logic       c;
        bit         need;
        for (int d = 0; d < 3; d++) begin
            rst[d]     = 1'b1;
            start[d]   = 1'b0;
            cont[d]    = 1'b0;
            mask[d]    = 4'd0;
            yv[d]      = 4'd0;
            frame_m[d] = 4'd0;
            s_m[d]     = 2'd0;
        end
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_s", d, 4'(s[d]), 4'd0);
            chk("rst_busy", d, 4'(busy[d]), 4'd0);
            chk("rst_sv", d, 4'(sv[d]), 4'd0);
            chk("rst_sch", d, 4'(sch[d]), 4'd0);
            chk("rst_sbit", d, 4'(sbit[d]), 4'd0);
            chk("rst_frame", d, frame[d], 4'd0);
            chk("rst_fv", d, 4'(fv[d]), 4'd0);
            rst[d] = 1'b0;
        end

        // Dwell 4, all channels, Y = 1,0,1,0 on ch0..3.
        yv[0] = 4'b0101;
        do_scan(0, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0);
        chk("t1_frame_lit", 0, frame[0], 4'b0101);
        idle_check(0, 2);

        // Dwell 2, sparse mask 1010.
        yv[1] = 4'b1010;
        do_scan(1, 4'b1010, 1'b0, 4'b1010, 1'b1, 1'b0);
        chk("t2_frame_lit", 1, frame[1], 4'b1010);
        idle_check(1, 2);

        // Start with an empty mask is ignored.
        start[2] = 1'b1;
        mask[2]  = 4'd0;
        step();
        start[2] = 1'b0;
        chk("zm_busy", 2, 4'(busy[2]), 4'd0);
        chk("zm_s", 2, 4'(s[2]), 4'd0);
        idle_check(2, 3);

        // Continuous: mask changed mid-frame, cont dropped during frame 2.
        yv[1] = 4'($urandom);
        do_scan(1, 4'b0011, 1'b1, 4'b0100, 1'b1, 1'b0);
        do_scan(1, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0);
        idle_check(1, 2);

        // Reset in the middle of channel 2 dwell.
        yv[0]    = 4'($urandom);
        start[0] = 1'b1;
        mask[0]  = 4'b1111;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_s", 0, 4'(s[0]), 4'd2);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        chk("mr_s", 0, 4'(s[0]), 4'd0);
        chk("mr_busy", 0, 4'(busy[0]), 4'd0);
        chk("mr_sv", 0, 4'(sv[0]), 4'd0);
        chk("mr_sch", 0, 4'(sch[0]), 4'd0);
        chk("mr_sbit", 0, 4'(sbit[0]), 4'd0);
        chk("mr_frame", 0, frame[0], 4'd0);
        chk("mr_fv", 0, 4'(fv[0]), 4'd0);
        frame_m[0] = 4'd0;
        s_m[0]     = 2'd0;
        idle_check(0, 8);
        do_scan(0, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b0);

        // Dwell 1 with a second start while busy.
        yv[2] = 4'($urandom);
        do_scan(2, 4'b1111, 1'b0, 4'b1111, 1'b1, 1'b1);
        idle_check(2, 2);

        // Randomized chains of frames on all three instances.
        for (int it = 0; it < 9; it++) begin
            int d;
            d    = it % 3;
            cur  = 4'($urandom_range(1, 15));
            need = 1'b1;
            for (int f = 0; f < 3; f++) begin
                yv[d] = 4'($urandom);
                c     = (f < 2) ? 1'($urandom) : 1'b0;
                nm    = 4'($urandom);
                do_scan(d, cur, c, nm, need, 1'($urandom));
                if (!(c && nm != 4'd0)) break;
                cur  = nm;
                need = 1'b0;
            end
            idle_check(d, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
